// File: rtl/machine_timer.sv
// machine_timer: memory-mapped RISC-V machine timer (mtime / mtimecmp).
//
// A free-running 64-bit timebase advanced by a programmable prescaler. It
// raises a level interrupt while mtime >= mtimecmp and IRQ_EN is set. The
// block sits on a dmem arbiter master port and uses the same
// valid/ready/addr/wdata/we/rdata slave handshake as the gpio and uart_wrap
// peripherals: one access per two cycles, ready_o pulsing one cycle after
// acceptance.
//
// Register window (word offset = addr_i[4:2]):
//   0x00 MTIME_LO     RW
//   0x04 MTIME_HI     RW
//   0x08 MTIMECMP_LO  RW
//   0x0C MTIMECMP_HI  RW
//   0x10 CTRL         RW  bit0 EN, bit1 IRQ_EN
//   0x14 PRESC        RW  low PRESC_W bits, tick every PRESC+1 cycles
//   0x18 STATUS       RO  bit0 = (mtime >= mtimecmp)
//   0x1C reserved         reads 0, writes ignored
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   valid_i  bus request valid, held by the master until ready_o
//   ready_o  one-cycle response pulse
//   addr_i   byte address (only [4:2] decoded)
//   wdata_i  write data
//   we_i     byte write enables, 0 = read
//   rdata_o  read data, valid with ready_o, held between responses
//   irq_o    registered level timer interrupt
//
// Optional build macro MACHINE_TIMER_HI_LATCH_EN:
//   When defined, a MTIME_LO read snapshots mtime[63:32] into a shadow. A
//   following MTIME_HI read returns that snapshot, so a LO-then-HI read pair
//   is tear-free. When undefined, MTIME_HI reads return the live upper word.

module machine_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          PRESC_W   = 16,
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  we_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam logic [2:0] OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_PRESC    = 3'd5;
  localparam logic [2:0] OFF_STATUS   = 3'd6;

  // Byte-lane merge: lanes with their enable set take the new value.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  logic               r_ready;
  logic [31:0]        r_rdata;
  logic               r_irq;
  logic [63:0]        r_mtime;
  logic [63:0]        r_mtimecmp;
  logic               r_en;
  logic               r_irq_en;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_cnt;

  logic               w_accept;
  logic               w_wr;
  logic               w_rd;
  logic [2:0]         w_off;
  logic               w_tick;
  logic               w_cmp_ge;
  logic [63:0]        w_mtime_inc;
  logic [63:0]        w_mtime_nxt;
  logic [63:0]        w_cmp_nxt;
  logic [31:0]        w_hi_rd;
  logic [31:0]        w_rdata_mux;
  logic               w_unused;

  // Only addr_i[4:2] selects a register; the base is fixed by the arbiter.
  assign w_unused = ^{addr_i[31:5], addr_i[1:0], BASE_ADDR};

  // A new request is only taken while no response is being presented.
  assign w_accept = valid_i & ~r_ready;
  assign w_wr     = w_accept & (we_i != 4'b0000);
  assign w_rd     = w_accept & (we_i == 4'b0000);
  assign w_off    = addr_i[4:2];

  assign w_tick      = r_en & (r_cnt == r_presc);
  assign w_cmp_ge    = (r_mtime >= r_mtimecmp);
  assign w_mtime_inc = r_mtime + 64'(w_tick);

  // Written bytes replace the incremented value lane by lane, so a carry out
  // of an unwritten lane never disturbs a lane the master just wrote.
  always_comb begin
    w_mtime_nxt = w_mtime_inc;
    if (w_wr && (w_off == OFF_MTIME_LO))
      w_mtime_nxt[31:0] = merge_bytes(w_mtime_inc[31:0], wdata_i, we_i);
    if (w_wr && (w_off == OFF_MTIME_HI))
      w_mtime_nxt[63:32] = merge_bytes(w_mtime_inc[63:32], wdata_i, we_i);
  end

  always_comb begin
    w_cmp_nxt = r_mtimecmp;
    if (w_wr && (w_off == OFF_CMP_LO))
      w_cmp_nxt[31:0] = merge_bytes(r_mtimecmp[31:0], wdata_i, we_i);
    if (w_wr && (w_off == OFF_CMP_HI))
      w_cmp_nxt[63:32] = merge_bytes(r_mtimecmp[63:32], wdata_i, we_i);
  end

`ifdef MACHINE_TIMER_HI_LATCH_EN
  logic [31:0] r_shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= 32'h0;
    end else if (w_rd && (w_off == OFF_MTIME_LO)) begin
      r_shadow <= r_mtime[63:32];
    end
  end

  assign w_hi_rd = r_shadow;
`else
  assign w_hi_rd = r_mtime[63:32];
`endif

  always_comb begin
    w_rdata_mux = 32'h0;
    case (w_off)
      OFF_MTIME_LO: w_rdata_mux = r_mtime[31:0];
      OFF_MTIME_HI: w_rdata_mux = w_hi_rd;
      OFF_CMP_LO:   w_rdata_mux = r_mtimecmp[31:0];
      OFF_CMP_HI:   w_rdata_mux = r_mtimecmp[63:32];
      OFF_CTRL:     w_rdata_mux = {30'h0, r_irq_en, r_en};
      OFF_PRESC:    w_rdata_mux = 32'(r_presc);
      OFF_STATUS:   w_rdata_mux = {31'h0, w_cmp_ge};
      default:      w_rdata_mux = 32'h0;
    endcase
  end

  // Bus response: reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_ready <= w_accept;
      if (w_accept) r_rdata <= w_rd ? w_rdata_mux : 32'h0;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_presc  <= '0;
    end else begin
      if (w_wr && (w_off == OFF_CTRL) && we_i[0]) begin
        r_en     <= wdata_i[0];
        r_irq_en <= wdata_i[1];
      end
      if (w_wr && (w_off == OFF_PRESC))
        r_presc <= PRESC_W'(merge_bytes(32'(r_presc), wdata_i, we_i));
    end
  end

  // Prescaler: any PRESC write restarts the count so the new period starts
  // cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_wr && (w_off == OFF_PRESC)) begin
      r_cnt <= '0;
    end else if (r_en) begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end
  end

  // Timebase, compare value and interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime    <= 64'h0;
      r_mtimecmp <= CMP_RESET;
      r_irq      <= 1'b0;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_cmp_nxt;
      r_irq      <= r_irq_en & w_cmp_ge;
    end
  end

  assign ready_o = r_ready;
  assign rdata_o = r_rdata;
  assign irq_o   = r_irq;

endmodule

// File: tb/tb_machine_timer.sv
module tb_machine_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  we_i;
  logic [31:0] rdata_o;
  logic        irq_o;

  int errors = 0;
  int checks = 0;

  machine_timer dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .we_i    (we_i),
    .rdata_o (rdata_o),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: request, response one cycle later, pulse gone the cycle after.
  task automatic bus(input logic [31:0] a, input logic [3:0] we,
                     input logic [31:0] wd, output logic [31:0] rd);
    valid_i = 1'b1;
    addr_i  = a;
    we_i    = we;
    wdata_i = wd;
    @(posedge clk); #1;
    chk("ready_pulse", 64'(ready_o), 64'd1);
    rd = rdata_o;
    valid_i = 1'b0;
    we_i    = 4'h0;
    @(posedge clk); #1;
    chk("ready_drop", 64'(ready_o), 64'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(a, 4'hF, d, r);
    chk("wr_rdata_zero", 64'(r), 64'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 4'h0, 32'h0, r);
    chk(tag, 64'(r), 64'(exp));
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] exp_hi;
    int first;

    rst     = 1'b1;
    valid_i = 1'b0;
    addr_i  = 32'h0;
    wdata_i = 32'h0;
    we_i    = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_rdata", 64'(rdata_o), 64'd0);
    chk("rst_irq",   64'(irq_o),   64'd0);
    rst = 1'b0;

    // Reset values of every offset.
    rd_chk("rst_mtime_lo", 32'h00, 32'h0);
    rd_chk("rst_mtime_hi", 32'h04, 32'h0);
    rd_chk("rst_cmp_lo",   32'h08, 32'hFFFF_FFFF);
    rd_chk("rst_cmp_hi",   32'h0C, 32'hFFFF_FFFF);
    rd_chk("rst_ctrl",     32'h10, 32'h0);
    rd_chk("rst_presc",    32'h14, 32'h0);
    rd_chk("rst_status",   32'h18, 32'h0);
    rd_chk("rst_resv",     32'h1C, 32'h0);
    chk("rst_irq_after_reads", 64'(irq_o), 64'd0);

    // Prescaler 3: one tick every 4 cycles.
    wr(32'h14, 32'd3);
    rd_chk("presc_rb", 32'h14, 32'd3);
    wr(32'h10, 32'd1);
    repeat (40) @(posedge clk);
    #1;
    rd_chk("presc3_mtime", 32'h00, 32'd10);
    wr(32'h10, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    rd_chk("en0_hold", 32'h00, 32'd11);

    // Interrupt at mtime == 20, ticking every cycle from 11.
    wr(32'h0C, 32'd0);
    wr(32'h08, 32'd20);
    wr(32'h14, 32'd0);
    wr(32'h10, 32'd3);
    first = -1;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if (irq_o === 1'b1) begin
        first = n;
        break;
      end
    end
    chk("irq_rise_cycle", 64'(first), 64'd9);
    rd_chk("status_set", 32'h18, 32'd1);
    chk("irq_held", 64'(irq_o), 64'd1);
    wr(32'h08, 32'd1000);
    chk("irq_drop", 64'(irq_o), 64'd0);

    // 64-bit wrap; compare true but IRQ_EN off keeps irq low.
    wr(32'h10, 32'd0);
    wr(32'h04, 32'hFFFF_FFFF);
    wr(32'h00, 32'hFFFF_FFFE);
    rd_chk("status_big", 32'h18, 32'd1);
    chk("irq_masked", 64'(irq_o), 64'd0);
    wr(32'h10, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rd_chk("wrap_hi", 32'h04, 32'd0);
    rd_chk("wrap_lo", 32'h00, 32'd4);

    // Byte write on a carry edge: byte1 takes 0xAB, byte0 keeps counting.
    wr(32'h10, 32'd0);
    wr(32'h04, 32'd0);
    wr(32'h00, 32'h0000_00FE);
    wr(32'h10, 32'd1);
    bus(32'h00, 4'b0010, 32'h0000_AB00, r);
    chk("bytewr_rdata", 64'(r), 64'd0);
    rd_chk("bytewr_lo", 32'h00, 32'h0000_AB01);
    rd_chk("bytewr_hi", 32'h04, 32'h0);

    // LO then HI across a carry into the upper word.
    wr(32'h10, 32'd0);
    wr(32'h04, 32'd1);
    wr(32'h00, 32'hFFFF_FFF0);
    wr(32'h10, 32'd1);
    rd_chk("latch_lo", 32'h00, 32'hFFFF_FFF1);
    repeat (32) @(posedge clk);
    #1;
`ifdef MACHINE_TIMER_HI_LATCH_EN
    exp_hi = 32'd1;
`else
    exp_hi = 32'd2;
`endif
    rd_chk("latch_hi", 32'h04, exp_hi);

    // Reset while a request is presented: no response is produced.
    valid_i = 1'b1;
    addr_i  = 32'h00;
    we_i    = 4'h0;
    rst     = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", 64'(ready_o), 64'd0);
    chk("midrst_rdata", 64'(rdata_o), 64'd0);
    valid_i = 1'b0;
    rst     = 1'b0;
    rd_chk("midrst_cmp_lo", 32'h08, 32'hFFFF_FFFF);
    rd_chk("midrst_mtime",  32'h00, 32'h0);
    rd_chk("midrst_ctrl",   32'h10, 32'h0);
    rd_chk("midrst_hi",     32'h04, 32'h0);
    chk("midrst_irq", 64'(irq_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
